// File: rtl/hello_message_streamer.sv
// Streams a constant message one character per beat over a valid/ready byte
// interface, with repeat count, inter-message gap and abort.
module hello_message_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSG_LEN = 13,
  parameter logic [MSG_LEN*DATA_WIDTH-1:0] MESSAGE = "Hello, World!",
  parameter int GAP_CYCLES = 4,
  parameter int REP_WIDTH = 8,
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REP_WIDTH-1:0]  repeat_count,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [IDX_W-1:0]      char_index,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  // Handshake: a beat transfers on a rising clk edge where tx_valid && tx_ready.
  // Once tx_valid is raised, tx_data/tx_last/char_index hold until that edge;
  // only abort or reset may withdraw a beat that has not transferred.

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);
  localparam logic FIRST_IS_LAST = (MSG_LEN == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             rst_sync;
  logic                   rst_int_n;
  logic [REP_WIDTH-1:0]   reps_left;
  logic [GAP_W-1:0]       gap_cnt;

  // First character sits in the most-significant slice, so shift it up to the top.
  function automatic logic [DATA_WIDTH-1:0] msg_char(input logic [IDX_W-1:0] idx);
    logic [MSG_LEN*DATA_WIDTH-1:0] shifted;
    shifted = MESSAGE << (int'(idx) * DATA_WIDTH);
    return shifted[MSG_LEN*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  // Reset asserts immediately and releases two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      char_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reps_left  <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // A beat handshaking in this same cycle has already transferred.
        state      <= IDLE;
        tx_data    <= '0;
        tx_valid   <= 1'b0;
        tx_last    <= 1'b0;
        char_index <= '0;
        busy       <= 1'b0;
        reps_left  <= '0;
        gap_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= SEND;
              reps_left  <= (repeat_count == '0) ? REP_ONE : repeat_count;
              char_index <= '0;
              tx_data    <= msg_char('0);
              tx_last    <= FIRST_IS_LAST;
              tx_valid   <= 1'b1;
              busy       <= 1'b1;
            end
          end

          SEND: begin
            if (tx_valid && tx_ready) begin
              if (!tx_last) begin
                char_index <= char_index + 1'b1;
                tx_data    <= msg_char(char_index + 1'b1);
                tx_last    <= ((char_index + 1'b1) == IDX_W'(MSG_LEN - 1));
              end else begin
                char_index <= '0;
                reps_left  <= reps_left - 1'b1;
                if (reps_left == REP_ONE) begin
                  state    <= DONE;
                  tx_valid <= 1'b0;
                  tx_data  <= '0;
                  tx_last  <= 1'b0;
                  done     <= 1'b1;
                end else if (GAP_CYCLES == 0) begin
                  tx_data <= msg_char('0);
                  tx_last <= FIRST_IS_LAST;
                end else begin
                  state    <= GAP;
                  tx_valid <= 1'b0;
                  tx_data  <= '0;
                  tx_last  <= 1'b0;
                  gap_cnt  <= '0;
                end
              end
            end
          end

          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state    <= SEND;
              gap_cnt  <= '0;
              tx_valid <= 1'b1;
              tx_data  <= msg_char('0);
              tx_last  <= FIRST_IS_LAST;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end

          DONE: begin
            // done was raised on entry; busy drops together with it.
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hello_message_streamer.sv
// Directed bench for hello_message_streamer: table of transfers checked against
// the expected character stream, plus reset, abort and single-character cases.
module tb_hello_message_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] repeat_count;
  logic       abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic [3:0] char_index;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  logic       start1;
  logic [7:0] repeat_count1;
  logic       abort1;
  logic [7:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1;
  logic       tx_last1;
  logic [0:0] char_index1;
  logic       busy1;
  logic       done1;
  logic [1:0] state_dbg1;

  int tests = 0;
  int failed = 0;
  string msg = "Hello, World!";
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] rc;
    int mode;        // 0: tx_ready always high, 1: 1,0,0,1 pattern
    int abort_at;    // abort with the handshake of this beat (0 = never)
    int restart_at;  // pulse start while busy after this beat (0 = never)
    int exp_beats;
    int exp_done;
    int exp_ngaps;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  hello_message_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .repeat_count(repeat_count),
    .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .char_index(char_index), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  hello_message_streamer #(
    .DATA_WIDTH(8), .MSG_LEN(1), .MESSAGE(8'h41), .GAP_CYCLES(0), .REP_WIDTH(8)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .repeat_count(repeat_count1),
    .abort(abort1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_last(tx_last1), .char_index(char_index1), .busy(busy1), .done(done1),
    .state_dbg(state_dbg1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    int beats, done_cnt, done_lat, last_hs, first_valid, gap_run, ngaps;
    int gap_err, stall_err, last_err, idx_err, data_err;
    bit timeout;
    logic end_valid;
    logic [1:0] end_state;
    logic rdy, prev_stall;
    logic [7:0] prev_data, exp_ch;
    logic [3:0] prev_idx;
    bit pat[4];
    v = vecs[n];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    beats = 0; done_cnt = 0; done_lat = -1; last_hs = -1; first_valid = -1;
    gap_run = 0; ngaps = 0; gap_err = 0; stall_err = 0; last_err = 0;
    idx_err = 0; data_err = 0; timeout = 1'b1; end_valid = 1'b1; end_state = 2'd3;
    prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    exp_q.delete();
    for (int b = 0; b < v.exp_beats; b++) exp_q.push_back(msg[b % 13]);

    start = 1'b1;
    repeat_count = v.rc;
    tx_ready = 1'b1;
    step();
    for (int c = 1; c <= 600; c++) begin
      start = 1'b0;
      abort = 1'b0;
      if (!busy) begin
        timeout = 1'b0;
        end_valid = tx_valid;
        end_state = state_dbg;
        break;
      end
      rdy = (v.mode == 0) ? 1'b1 : pat[(c - 1) % 4];
      tx_ready = rdy;
      if (tx_valid && first_valid < 0) first_valid = c;
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data || char_index !== prev_idx))
        stall_err++;
      if (done) begin
        done_cnt++;
        done_lat = c - last_hs;
      end
      if (tx_valid) begin
        if (gap_run > 0) begin
          ngaps++;
          if (gap_run != 4) gap_err++;
        end
        gap_run = 0;
        if (int'(char_index) != beats % 13) idx_err++;
        if (tx_last !== ((beats % 13) == 12)) last_err++;
      end else if (beats > 0 && !done) begin
        gap_run++;
      end
      if (tx_valid && rdy) begin
        if (exp_q.size() == 0) data_err++;
        else begin
          exp_ch = exp_q.pop_front();
          if (tx_data !== exp_ch) data_err++;
        end
        beats++;
        last_hs = c;
        if (beats == v.abort_at) abort = 1'b1;
      end
      if (v.restart_at > 0 && beats == v.restart_at) begin
        start = 1'b1;
        repeat_count = 8'd5;
      end
      prev_stall = tx_valid && !rdy;
      prev_data = tx_data;
      prev_idx = char_index;
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    tx_ready = 1'b1;

    check($sformatf("v%0d timeout", n), int'(timeout), 0);
    check($sformatf("v%0d first_valid_latency", n), first_valid, 1);
    check($sformatf("v%0d beats", n), beats, v.exp_beats);
    check($sformatf("v%0d data_errors", n), data_err, 0);
    check($sformatf("v%0d char_index_errors", n), idx_err, 0);
    check($sformatf("v%0d tx_last_errors", n), last_err, 0);
    check($sformatf("v%0d stall_errors", n), stall_err, 0);
    check($sformatf("v%0d gap_count", n), ngaps, v.exp_ngaps);
    check($sformatf("v%0d gap_length_errors", n), gap_err, 0);
    check($sformatf("v%0d done_pulses", n), done_cnt, v.exp_done);
    if (v.exp_done > 0) check($sformatf("v%0d done_latency", n), done_lat, 1);
    check($sformatf("v%0d end_tx_valid", n), int'(end_valid), 0);
    check($sformatf("v%0d end_state_idle", n), int'(end_state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    vecs[0] = '{8'd1, 0, 0, 0, 13, 1, 0};
    vecs[1] = '{8'd3, 0, 0, 0, 39, 1, 2};
    vecs[2] = '{8'd1, 1, 0, 0, 13, 1, 0};
    vecs[3] = '{8'd0, 0, 0, 3, 13, 1, 0};
    vecs[4] = '{8'd1, 0, 5, 0,  5, 0, 0};
    vecs[5] = '{8'd2, 1, 0, 0, 26, 1, 1};

    rst_n = 1'b0; start = 1'b0; repeat_count = '0; abort = 1'b0; tx_ready = 1'b1;
    start1 = 1'b0; repeat_count1 = '0; abort1 = 1'b0; tx_ready1 = 1'b1;

    // reset state
    repeat (3) step();
    check("reset tx_valid", int'(tx_valid), 0);
    check("reset tx_data", int'(tx_data), 0);
    check("reset tx_last", int'(tx_last), 0);
    check("reset char_index", int'(char_index), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    #2 rst_n = 1'b1;
    repeat (4) step();
    check("post_reset busy", int'(busy), 0);
    check("post_reset state", int'(state_dbg), 0);

    // abort and start together in IDLE: abort wins
    start = 1'b1; repeat_count = 8'd1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("idle abort+start busy", int'(busy), 0);
    check("idle abort+start tx_valid", int'(tx_valid), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle abort state", int'(state_dbg), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(i);
      repeat (2) step();
    end

    // reset asserted mid-message, off the clock edge
    start = 1'b1; repeat_count = 8'd1; tx_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("mid_reset pre tx_valid", int'(tx_valid), 1);
    check("mid_reset pre char_index", int'(char_index), 6);
    #3 rst_n = 1'b0;
    #1;
    check("mid_reset tx_valid", int'(tx_valid), 0);
    check("mid_reset busy", int'(busy), 0);
    check("mid_reset char_index", int'(char_index), 0);
    check("mid_reset tx_data", int'(tx_data), 0);
    #7 rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (busy !== 1'b0 || tx_valid !== 1'b0) errs++;
    end
    check("post_mid_reset idle", errs, 0);
    run_vec(0);
    repeat (2) step();

    // single-character message, no gap: every beat is last, back-to-back
    start1 = 1'b1; repeat_count1 = 8'd3;
    step();
    start1 = 1'b0;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      if (tx_valid1 !== 1'b1 || tx_data1 !== 8'h41 || tx_last1 !== 1'b1 ||
          char_index1 !== 1'b0 || done1 !== 1'b0) errs++;
      step();
    end
    check("len1 beat_errors", errs, 0);
    check("len1 done", int'(done1), 1);
    check("len1 done tx_valid", int'(tx_valid1), 0);
    step();
    check("len1 busy_after", int'(busy1), 0);
    check("len1 done_after", int'(done1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
